maze_mem: RTL and testbench

MAZE_MEM -- requirements
Module: maze_mem

---
 rtl/maze_mem.sv | 152 +++++++++++++++
 tb/tb_maze_mem.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/maze_mem.sv
// Maze cell store: 64x64 array of 2-bit cells, raster-order load from a
// bit stream, solver read/mark-visited port, then raster-order dump.
module maze_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    input  logic        load_data,
    output logic        load_ready,
    output logic        loaded,
    input  logic [5:0]  row,
    input  logic [5:0]  col,
    input  logic        maze_oe,
    input  logic        maze_we,
    output logic        maze_in,
    input  logic        done,
    output logic        dump_valid,
    output logic [1:0]  dump_data,
    output logic        dump_last,
    input  logic        dump_ready,
    output logic [12:0] visited_count
);

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned N_CELLS = 4096;
    localparam int unsigned CNT_W   = 13;

    localparam logic [1:0]        CELL_FREE    = 2'b00;
    localparam logic [1:0]        CELL_VISITED = 2'b10;
    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(N_CELLS - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SOLVE,
        S_DUMP,
        S_FINISHED
    } state_t;

    state_t             r_state;
    logic [1:0]         r_mem [N_CELLS];
    logic [ADDR_W-1:0]  r_ld_addr;
    logic [ADDR_W-1:0]  r_dp_addr;
    logic               r_load_ready;
    logic               r_loaded;
    logic               r_maze_in;
    logic               r_dump_valid;
    logic [1:0]         r_dump_data;
    logic               r_dump_last;
    logic [CNT_W-1:0]   r_visited;

    logic [ADDR_W-1:0]  w_addr;
    logic [1:0]         w_cell;
    logic               w_ld_fire;
    logic               w_mark;
    logic               w_new_visit;
    logic [ADDR_W-1:0]  w_dp_next;

    // Solver address decode and write qualification; bit0 is the wall bit
    always_comb begin
        w_addr      = {row, col};
        w_cell      = r_mem[w_addr];
        w_ld_fire   = (r_state == S_LOAD) && load_valid;
        w_mark      = (r_state == S_SOLVE) && maze_we && !w_cell[0];
        w_new_visit = w_mark && (w_cell == CELL_FREE);
        w_dp_next   = r_dp_addr + ADDR_W'(1);
    end

    // Cell array: not reset, fully rewritten by every load
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_ld_fire) begin
                r_mem[r_ld_addr] <= {1'b0, load_data};
            end else if (w_mark) begin
                r_mem[w_addr] <= CELL_VISITED;
            end
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_LOAD;
            r_ld_addr    <= '0;
            r_dp_addr    <= '0;
            r_load_ready <= 1'b1;
            r_loaded     <= 1'b0;
            r_maze_in    <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_data  <= 2'b00;
            r_dump_last  <= 1'b0;
            r_visited    <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_ld_fire) begin
                        r_ld_addr <= r_ld_addr + ADDR_W'(1);
                        if (r_ld_addr == LAST_ADDR) begin
                            r_state      <= S_SOLVE;
                            r_load_ready <= 1'b0;
                            r_loaded     <= 1'b1;
                        end
                    end
                end
                S_SOLVE: begin
                    if (maze_oe) begin
                        r_maze_in <= w_cell[0];
                    end
                    if (w_new_visit) begin
                        r_visited <= r_visited + CNT_W'(1);
                    end
                    if (done) begin
                        r_state      <= S_DUMP;
                        r_dp_addr    <= '0;
                        r_dump_valid <= 1'b1;
                        r_dump_last  <= 1'b0;
                        // Forward a same-edge mark of cell (0,0) into the first dump word
                        r_dump_data  <= (w_mark && (w_addr == '0)) ? CELL_VISITED
                                                                    : r_mem[ADDR_W'(0)];
                    end
                end
                S_DUMP: begin
                    if (dump_ready) begin
                        if (r_dump_last) begin
                            r_state      <= S_FINISHED;
                            r_dump_valid <= 1'b0;
                            r_dump_last  <= 1'b0;
                            r_dump_data  <= 2'b00;
                        end else begin
                            r_dp_addr   <= w_dp_next;
                            r_dump_data <= r_mem[w_dp_next];
                            r_dump_last <= (w_dp_next == LAST_ADDR);
                        end
                    end
                end
                S_FINISHED: begin
                    r_state <= S_FINISHED;
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    assign load_ready    = r_load_ready;
    assign loaded        = r_loaded;
    assign maze_in       = r_maze_in;
    assign dump_valid    = r_dump_valid;
    assign dump_data     = r_dump_data;
    assign dump_last     = r_dump_last;
    assign visited_count = r_visited;

endmodule

// File: tb/tb_maze_mem.sv
// Directed bench for maze_mem: load, solver read/mark, dump and reset cases.
module tb_maze_mem;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic        load_data;
    logic        load_ready;
    logic        loaded;
    logic [5:0]  row;
    logic [5:0]  col;
    logic        maze_oe;
    logic        maze_we;
    logic        maze_in;
    logic        done;
    logic        dump_valid;
    logic [1:0]  dump_data;
    logic        dump_last;
    logic        dump_ready;
    logic [12:0] visited_count;

    logic [1:0]  model [4096];
    int          n_vec;
    int          n_err;

    maze_mem dut (
        .clk           (clk),
        .rst           (rst),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_ready    (load_ready),
        .loaded        (loaded),
        .row           (row),
        .col           (col),
        .maze_oe       (maze_oe),
        .maze_we       (maze_we),
        .maze_in       (maze_in),
        .done          (done),
        .dump_valid    (dump_valid),
        .dump_data     (dump_data),
        .dump_last     (dump_last),
        .dump_ready    (dump_ready),
        .visited_count (visited_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream the model's wall bits; toggle=1 drives load_valid every other cycle
    task automatic load_all(input bit toggle);
        int   idx;
        int   cyc;
        logic rdy;
        idx = 0;
        cyc = 0;
        while (idx < 4096 && cyc < 10000) begin
            load_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            load_data  = model[idx][0];
            rdy        = load_ready;
            if (idx == 4095 && load_valid) check("loaded_before_last", 13'(loaded), 13'd0);
            tick();
            if (load_valid && rdy) idx++;
            cyc++;
        end
        load_valid = 1'b0;
        check("load_accepts", 13'(idx), 13'd4096);
        check("load_cycles", 13'(cyc), toggle ? 13'd8191 : 13'd4096);
        check("loaded_after", 13'(loaded), 13'd1);
        check("load_ready_after", 13'(load_ready), 13'd0);
        tick();
        check("load_ready_stays0", 13'(load_ready), 13'd0);
    endtask

    task automatic solver(input logic [5:0] r, input logic [5:0] c, input logic oe, input logic we);
        row     = r;
        col     = c;
        maze_oe = oe;
        maze_we = we;
        tick();
        maze_oe = 1'b0;
        maze_we = 1'b0;
    endtask

    initial begin
        int ptr;
        int cyc;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; load_valid = 1'b0; load_data = 1'b0; row = '0; col = '0;
        maze_oe = 1'b0; maze_we = 1'b0; done = 1'b0; dump_ready = 1'b0;

        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                model[r*64 + c] = (((r + c) % 3) == 0) ? 2'b01 : 2'b00;
        model[5*64 + 7] = 2'b01;

        // Reset values
        #12;
        check("rst_load_ready", 13'(load_ready), 13'd1);
        check("rst_loaded", 13'(loaded), 13'd0);
        check("rst_maze_in", 13'(maze_in), 13'd0);
        check("rst_dump_valid", 13'(dump_valid), 13'd0);
        check("rst_visited", visited_count, 13'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Toggled load; solver inputs and done must be ignored during LOAD
        done = 1'b1; maze_we = 1'b1; row = 6'd10; col = 6'd10;
        tick(); tick();
        done = 1'b0; maze_we = 1'b0;
        check("load_ignore_done", 13'(dump_valid), 13'd0);
        load_all(1'b1);
        check("solve_visited0", visited_count, 13'd0);
        check("solve_dump_valid0", 13'(dump_valid), 13'd0);

        // Reads: wall, hold while maze_oe low, free cell
        solver(6'd5, 6'd7, 1'b1, 1'b0);
        check("read_wall_5_7", 13'(maze_in), 13'd1);
        row = 6'd5; col = 6'd8;
        tick(); tick();
        check("read_hold", 13'(maze_in), 13'd1);
        solver(6'd5, 6'd8, 1'b1, 1'b0);
        check("read_free_5_8", 13'(maze_in), 13'd0);
        solver(6'd0, 6'd3, 1'b1, 1'b0);
        check("read_wall_0_3", 13'(maze_in), 13'd1);

        // Marks: free cell twice, wall once
        solver(6'd10, 6'd10, 1'b0, 1'b1);
        solver(6'd10, 6'd10, 1'b0, 1'b1);
        solver(6'd5, 6'd7, 1'b0, 1'b1);
        check("visited_after_marks", visited_count, 13'd1);
        model[10*64 + 10] = 2'b10;
        solver(6'd10, 6'd10, 1'b1, 1'b0);
        check("read_visited_is0", 13'(maze_in), 13'd0);

        // Simultaneous read and mark of a free cell returns pre-write value
        solver(6'd0, 6'd3, 1'b1, 1'b0);
        solver(6'd20, 6'd20, 1'b1, 1'b1);
        check("rdwr_maze_in", 13'(maze_in), 13'd0);
        check("rdwr_visited", visited_count, 13'd2);
        model[20*64 + 20] = 2'b10;

        // Dump with initial backpressure; marks during DUMP are ignored
        done = 1'b1;
        tick();
        done = 1'b0;
        row = 6'd10; col = 6'd12; maze_we = 1'b1;
        for (int k = 0; k < 5; k++) begin
            dump_ready = 1'b0;
            check("hold_valid", 13'(dump_valid), 13'd1);
            check("hold_data", 13'(dump_data), 13'(model[0]));
            check("hold_last", 13'(dump_last), 13'd0);
            tick();
        end
        dump_ready = 1'b1;
        ptr = 0;
        cyc = 0;
        while (ptr < 4096 && cyc < 5000) begin
            check("dump_valid", 13'(dump_valid), 13'd1);
            check("dump_data", 13'(dump_data), 13'(model[ptr]));
            check("dump_last", 13'(dump_last), (ptr == 4095) ? 13'd1 : 13'd0);
            tick();
            ptr++;
            cyc++;
        end
        maze_we = 1'b0;
        check("dump_words", 13'(ptr), 13'd4096);
        check("fin_dump_valid", 13'(dump_valid), 13'd0);
        tick(); tick();
        check("fin_dump_valid_hold", 13'(dump_valid), 13'd0);
        check("fin_load_ready", 13'(load_ready), 13'd0);
        check("fin_visited", visited_count, 13'd2);
        dump_ready = 1'b0;

        // Reset, reload, dirty the outputs, then reset in the middle of a dump
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load_all(1'b0);
        solver(6'd5, 6'd7, 1'b1, 1'b0);
        solver(6'd30, 6'd31, 1'b0, 1'b1);
        check("pre_rst_visited", visited_count, 13'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        dump_ready = 1'b1;
        for (int k = 0; k < 100; k++) tick();
        dump_ready = 1'b0;
        check("pre_rst_dump_valid", 13'(dump_valid), 13'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_dump_valid", 13'(dump_valid), 13'd0);
        check("mid_rst_dump_data", 13'(dump_data), 13'd0);
        check("mid_rst_dump_last", 13'(dump_last), 13'd0);
        check("mid_rst_load_ready", 13'(load_ready), 13'd1);
        check("mid_rst_loaded", 13'(loaded), 13'd0);
        check("mid_rst_maze_in", 13'(maze_in), 13'd0);
        check("mid_rst_visited", visited_count, 13'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        load_all(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
